// File: rtl/clock_pkg.sv
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared state encoding, BCD limits and digit indices for the
//                time-of-day core.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } clk_state_t;

    localparam logic [3:0] c_digit_max        = 4'd9;
    localparam logic [3:0] c_ms_tens_max      = 4'd5;
    localparam logic [3:0] c_hr_tens_max      = 4'd2;
    localparam logic [3:0] c_hr_units_max_at2 = 4'd3;

    localparam int c_idx_sec0  = 0;
    localparam int c_idx_sec1  = 1;
    localparam int c_idx_min0  = 2;
    localparam int c_idx_min1  = 3;
    localparam int c_idx_hour0 = 4;
    localparam int c_idx_hour1 = 5;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
//  Module      : btn_debounce
//  Description : 2-FF synchroniser, stability counter and rising-edge pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press_p
);

    localparam int c_cnt_w = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic               r_stable_d;
    logic [c_cnt_w-1:0] r_cnt;

    // Accepted level only flips after the synchronised level has differed
    // from it for DB_CYCLES consecutive cycles; any bounce restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= btn_raw;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign press_p = r_stable & ~r_stable_d;

endmodule

`default_nettype wire

// File: rtl/bcd_clock_core.sv
// ============================================================================
//  Module      : bcd_clock_core
//  Description : 24-hour BCD time-of-day counter with two-button time setting.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_clock_core
    import clock_pkg::*;
#(
    parameter int CLK_DIV   = 100000000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] sec0,
    output logic [3:0] sec1,
    output logic [3:0] min0,
    output logic [3:0] min1,
    output logic [3:0] hour0,
    output logic [3:0] hour1,
    output logic [5:0] blink_mask,
    output logic       sec_pulse
);

    localparam int c_div_w = $clog2(CLK_DIV);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

    clk_state_t         r_state;
    clk_state_t         w_state_next;
    logic [c_div_w-1:0] r_div;
    logic [3:0]         r_sec0, r_sec1, r_min0, r_min1, r_hour0, r_hour1;
    logic               r_sec_pulse;
    logic               w_mode_p, w_inc_p, w_tick;
    logic [5:0]         w_blink;
    logic [3:0]         w_sec0_nx, w_sec1_nx, w_min0_nx, w_min1_nx;
    logic [3:0]         w_hour0_nx, w_hour1_nx;
    logic               w_sec_wrap, w_min_wrap;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_mode),
        .press_p (w_mode_p)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_inc),
        .press_p (w_inc_p)
    );

    assign w_tick = (r_state == ST_RUN) && (r_div == c_div_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_blink      = '0;
        case (r_state)
            ST_RUN: begin
                if (w_mode_p) w_state_next = ST_SET_HOUR;
            end
            ST_SET_HOUR: begin
                w_blink[c_idx_hour1] = 1'b1;
                w_blink[c_idx_hour0] = 1'b1;
                if (w_mode_p) w_state_next = ST_SET_MIN;
            end
            ST_SET_MIN: begin
                w_blink[c_idx_min1] = 1'b1;
                w_blink[c_idx_min0] = 1'b1;
                if (w_mode_p) w_state_next = ST_RUN;
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    // Held at zero outside RUN and on the RUN->SET edge, so leaving SET_MIN
    // always restarts a full CLK_DIV period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
        end else if ((r_state != ST_RUN) || w_mode_p || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Per-field successors; the tick cascade and the edit buttons share them.
    always_comb begin
        w_sec_wrap = (r_sec1 == c_ms_tens_max) && (r_sec0 == c_digit_max);
        w_min_wrap = (r_min1 == c_ms_tens_max) && (r_min0 == c_digit_max);

        w_sec0_nx = r_sec0 + 4'd1;
        w_sec1_nx = r_sec1;
        if (r_sec0 == c_digit_max) begin
            w_sec0_nx = 4'd0;
            w_sec1_nx = (r_sec1 == c_ms_tens_max) ? 4'd0 : r_sec1 + 4'd1;
        end

        w_min0_nx = r_min0 + 4'd1;
        w_min1_nx = r_min1;
        if (r_min0 == c_digit_max) begin
            w_min0_nx = 4'd0;
            w_min1_nx = (r_min1 == c_ms_tens_max) ? 4'd0 : r_min1 + 4'd1;
        end

        w_hour0_nx = r_hour0 + 4'd1;
        w_hour1_nx = r_hour1;
        if ((r_hour1 == c_hr_tens_max) && (r_hour0 == c_hr_units_max_at2)) begin
            w_hour0_nx = 4'd0;
            w_hour1_nx = 4'd0;
        end else if (r_hour0 == c_digit_max) begin
            w_hour0_nx = 4'd0;
            w_hour1_nx = r_hour1 + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sec0      <= 4'd0;
            r_sec1      <= 4'd0;
            r_min0      <= 4'd0;
            r_min1      <= 4'd0;
            r_hour0     <= 4'd0;
            r_hour1     <= 4'd0;
            r_sec_pulse <= 1'b0;
        end else begin
            r_sec_pulse <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    // A mode press wins over a coincident tick.
                    if (!w_mode_p && w_tick) begin
                        r_sec_pulse <= 1'b1;
                        r_sec0      <= w_sec0_nx;
                        r_sec1      <= w_sec1_nx;
                        if (w_sec_wrap) begin
                            r_min0 <= w_min0_nx;
                            r_min1 <= w_min1_nx;
                            if (w_min_wrap) begin
                                r_hour0 <= w_hour0_nx;
                                r_hour1 <= w_hour1_nx;
                            end
                        end
                    end
                end
                ST_SET_HOUR: begin
                    if (!w_mode_p && w_inc_p) begin
                        r_hour0 <= w_hour0_nx;
                        r_hour1 <= w_hour1_nx;
                    end
                end
                ST_SET_MIN: begin
                    if (w_mode_p) begin
                        r_sec0 <= 4'd0;
                        r_sec1 <= 4'd0;
                    end else if (w_inc_p) begin
                        r_min0 <= w_min0_nx;
                        r_min1 <= w_min1_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sec0       = r_sec0;
    assign sec1       = r_sec1;
    assign min0       = r_min0;
    assign min1       = r_min1;
    assign hour0      = r_hour0;
    assign hour1      = r_hour1;
    assign blink_mask = w_blink;
    assign sec_pulse  = r_sec_pulse;

endmodule

`default_nettype wire

// File: tb/tb_bcd_clock_core.sv
// ============================================================================
//  Module      : tb_bcd_clock_core
//  Description : Self-checking bench for bcd_clock_core (CLK_DIV=4, DB=2).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_clock_core;

    localparam int P_CLK_DIV = 4;
    localparam int P_DB      = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_mode;
    logic       btn_inc;
    logic [3:0] sec0, sec1, min0, min1, hour0, hour1;
    logic [5:0] blink_mask;
    logic       sec_pulse;

    int n_cmp = 0;
    int n_err = 0;
    int pulse_total = 0;

    typedef struct packed {
        logic [1:0]  btn;   // bit0 = mode, bit1 = inc
        logic [29:0] exp;   // {hour, min, sec, blink_mask}
    } vec_t;

    vec_t        vecs [87];
    logic [29:0] sb_q [$];

    bcd_clock_core #(.CLK_DIV(P_CLK_DIV), .DB_CYCLES(P_DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .sec0       (sec0),
        .sec1       (sec1),
        .min0       (min0),
        .min1       (min1),
        .hour0      (hour0),
        .hour1      (hour1),
        .blink_mask (blink_mask),
        .sec_pulse  (sec_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (sec_pulse === 1'b1) pulse_total++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    function automatic logic [29:0] cur();
        return {hour1, hour0, min1, min0, sec1, sec0, blink_mask};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raw button high for 6 cycles, low for 6; the action lands 5 edges in.
    task automatic press(input logic [1:0] which);
        @(posedge clk);
        #1;
        btn_mode = which[0];
        btn_inc  = which[1];
        cyc(6);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        cyc(6);
    endtask

    initial begin
        logic [29:0] exp_v;
        int          nv;
        int          base;

        // {btn, expected time/blink} table; seconds stay frozen at 37
        nv = 0;
        vecs[nv] = '{btn: 2'd1, exp: {8'h00, 8'h00, 8'h37, 6'b110000}}; nv++;
        for (int i = 1; i <= 25; i++) begin
            vecs[nv] = '{btn: 2'd2, exp: {to_bcd(i % 24), 8'h00, 8'h37, 6'b110000}}; nv++;
        end
        vecs[nv] = '{btn: 2'd3, exp: {8'h01, 8'h00, 8'h37, 6'b001100}}; nv++;
        for (int i = 1; i <= 59; i++) begin
            vecs[nv] = '{btn: 2'd2, exp: {8'h01, to_bcd(i), 8'h37, 6'b001100}}; nv++;
        end
        vecs[nv] = '{btn: 2'd2, exp: {8'h01, 8'h00, 8'h37, 6'b001100}}; nv++;

        // ---------------- reset and free-running count ----------------
        rst      = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        cyc(3);
        check("reset_state", 32'({cur(), sec_pulse}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc(41);
        check("count_40cyc", 32'(cur()), 32'({8'h00, 8'h00, 8'h10, 6'b0}));
        check("pulse_count_10", 32'(pulse_total), 32'd10);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", 32'({cur(), sec_pulse}), 32'd0);
        cyc(2);
        @(negedge clk);
        rst = 1'b1;

        // Enter SET_HOUR so that the freeze edge coincides with a tick
        // (dropped): 151 edges in RUN -> 37 seconds.
        repeat (146) @(posedge clk);

        // ---------------- table: hour edit, simultaneous, minute edit ----
        for (int i = 0; i < 87; i++) begin
            sb_q.push_back(vecs[i].exp);
            press(vecs[i].btn);
            exp_v = sb_q.pop_front();
            check($sformatf("vec%0d", i), 32'(cur()), 32'(exp_v));
        end

        // ---------------- exit SET_MIN: seconds cleared, tick 4 cycles later
        @(posedge clk);
        #1;
        btn_mode = 1'b1;
        cyc(5);
        check("exit_run", 32'({cur(), sec_pulse}), 32'({8'h01, 8'h00, 8'h00, 6'b0, 1'b0}));
        cyc(3);
        check("exit_no_tick_3", 32'({sec1, sec0, sec_pulse}), 32'({8'h00, 1'b0}));
        cyc(1);
        check("exit_tick_4", 32'({sec1, sec0, sec_pulse}), 32'({8'h01, 1'b1}));
        btn_mode = 1'b0;
        cyc(8);

        // ---------------- set 23:59 with debounce checks -----------------
        press(2'd1);
        for (int i = 0; i < 22; i++) press(2'd2);
        check("hour_23", 32'({hour1, hour0, blink_mask}), 32'({8'h23, 6'b110000}));
        press(2'd1);
        check("min_start", 32'({min1, min0, blink_mask}), 32'({8'h00, 6'b001100}));

        @(posedge clk);
        #1;
        btn_inc = 1'b1;
        cyc(1);
        btn_inc = 1'b0;
        cyc(10);
        check("glitch_ignored", 32'({min1, min0}), 32'h00);

        @(posedge clk);
        #1;
        btn_inc = 1'b1;
        cyc(4);
        check("hold_before", 32'({min1, min0}), 32'h00);
        cyc(1);
        check("hold_after", 32'({min1, min0}), 32'h01);
        cyc(5);
        btn_inc = 1'b0;
        cyc(10);
        check("hold_once", 32'({min1, min0}), 32'h01);

        for (int i = 0; i < 58; i++) press(2'd2);
        check("preset_2359", 32'({hour1, hour0, min1, min0}), 32'h2359);

        // ---------------- full rollover ----------------------------------
        press(2'd1);
        cyc(225);
        check("roll_58", 32'({cur(), sec_pulse}), 32'({8'h23, 8'h59, 8'h58, 6'b0, 1'b1}));
        cyc(1);
        base = pulse_total;
        cyc(3);
        check("roll_59", 32'({cur(), sec_pulse}), 32'({8'h23, 8'h59, 8'h59, 6'b0, 1'b1}));
        cyc(4);
        check("roll_00", 32'({cur(), sec_pulse}), 32'({8'h00, 8'h00, 8'h00, 6'b0, 1'b1}));
        cyc(1);
        check("roll_pulses", 32'(pulse_total - base), 32'd2);

        // ---------------- reset aborts an edit ---------------------------
        @(posedge clk);
        #1;
        btn_mode = 1'b1;
        cyc(6);
        check("edit_entered", 32'(blink_mask), 32'(6'b110000));
        btn_mode = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("edit_abort", 32'({cur(), sec_pulse}), 32'd0);
        cyc(2);
        rst = 1'b1;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
